// File: rtl/rv_fetch_queue.sv
// Halfword prefetch queue between the instruction-fetch bus and decode.
// Accepts 32-bit fetch words and presents one RV32 or RVC instruction per cycle with its PC.
module rv_fetch_queue #(
  parameter int IADDR_SPACE_BITS = 16,
  parameter int HW               = 16,
  parameter int DEPTH_BITS       = 3
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic [IADDR_SPACE_BITS-1:1]   i_reset_pc,
  input  logic                          i_flush,
  input  logic [IADDR_SPACE_BITS-1:1]   i_flush_pc,
  input  logic                          i_push_valid,
  input  logic [2*HW-1:0]               i_push_data,
  input  logic                          i_push_skip_lo,
  output logic                          o_push_ready,
  output logic                          o_instr_valid,
  output logic [2*HW-1:0]               o_instr,
  output logic                          o_is_comp,
  output logic [IADDR_SPACE_BITS-1:1]   o_pc,
  output logic [IADDR_SPACE_BITS-1:1]   o_pc_next,
  input  logic                          i_pop,
  output logic [DEPTH_BITS:0]           o_count
);

  localparam int QSIZE = 2 ** DEPTH_BITS;
  localparam int CW    = DEPTH_BITS + 1;
  localparam int PW    = IADDR_SPACE_BITS - 1;

  logic [HW-1:0]               mem_q [QSIZE];
  logic [HW-1:0]               mem_d [QSIZE];
  logic [HW-1:0]               ext_s [QSIZE+2];
  logic [HW-1:0]               sh_s  [QSIZE];
  logic [CW-1:0]               count_q, count_d;
  logic [IADDR_SPACE_BITS-1:1] pc_q, pc_d;
  logic [IADDR_SPACE_BITS-1:1] pc_next_s;
  logic [CW-1:0]               pop_amt_s, push_amt_s, wr_idx_s;
  logic                        is_comp_s, instr_valid_s, push_ready_s, pop_s, push_s;
  logic [HW-1:0]               wr_lo_s, wr_hi_s;

  assign is_comp_s     = (count_q != CW'(0)) && (mem_q[0][1:0] != 2'b11);
  assign instr_valid_s = is_comp_s || (count_q >= CW'(2));
  assign push_ready_s  = (count_q <= CW'(QSIZE - 2));
  assign pop_s         = i_pop && instr_valid_s;
  assign push_s        = i_push_valid && push_ready_s;
  assign pop_amt_s     = pop_s ? (is_comp_s ? CW'(1) : CW'(2)) : CW'(0);
  assign push_amt_s    = push_s ? (i_push_skip_lo ? CW'(1) : CW'(2)) : CW'(0);
  assign wr_idx_s      = count_q - pop_amt_s;
  // On skip_lo only the upper halfword enters the queue, landing at the write index.
  assign wr_lo_s       = i_push_skip_lo ? i_push_data[2*HW-1:HW] : i_push_data[HW-1:0];
  assign wr_hi_s       = i_push_data[2*HW-1:HW];
  assign pc_next_s     = pc_q + (is_comp_s ? PW'(1) : PW'(2));

  assign o_push_ready  = push_ready_s;
  assign o_instr_valid = instr_valid_s;
  assign o_is_comp     = is_comp_s;
  assign o_instr       = is_comp_s ? {{HW{1'b0}}, mem_q[0]} : {mem_q[1], mem_q[0]};
  assign o_pc          = pc_q;
  assign o_pc_next     = pc_next_s;
  assign o_count       = count_q;

  // Shift surviving entries down by the pop amount, then overlay pushed halfwords.
  always_comb begin
    for (int i = 0; i < QSIZE; i++) begin
      ext_s[i] = mem_q[i];
    end
    ext_s[QSIZE]   = {HW{1'b0}};
    ext_s[QSIZE+1] = {HW{1'b0}};
    for (int i = 0; i < QSIZE; i++) begin
      case (pop_amt_s)
        CW'(1):  sh_s[i] = ext_s[i+1];
        CW'(2):  sh_s[i] = ext_s[i+2];
        default: sh_s[i] = ext_s[i];
      endcase
      if (push_s && (CW'(i) == wr_idx_s)) begin
        mem_d[i] = wr_lo_s;
      end else if (push_s && !i_push_skip_lo && (CW'(i) == wr_idx_s + CW'(1))) begin
        mem_d[i] = wr_hi_s;
      end else begin
        mem_d[i] = sh_s[i];
      end
    end
  end

  // Next occupancy and head PC; flush overrides any concurrent push or pop.
  always_comb begin
    count_d = count_q;
    pc_d    = pc_q;
    if (i_flush) begin
      count_d = CW'(0);
      pc_d    = i_flush_pc;
    end else if (pop_s) begin
      count_d = count_q - pop_amt_s + push_amt_s;
      pc_d    = pc_next_s;
    end else begin
      count_d = count_q + push_amt_s;
      pc_d    = pc_q;
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      count_q <= CW'(0);
      pc_q    <= i_reset_pc;
    end else begin
      count_q <= count_d;
      pc_q    <= pc_d;
    end
  end

  // Queue storage; contents are don't-care whenever count is zero, so no reset.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_rv_fetch_queue.sv
// Bench for rv_fetch_queue: directed vector table, a reset corner case and a
// randomized phase checked against a halfword-queue reference model.
module tb_rv_fetch_queue;

  localparam int QS = 8;

  logic        clk;
  logic        reset_n;
  logic [14:0] reset_pc;
  logic        flush;
  logic [14:0] flush_pc;
  logic        push_valid;
  logic [31:0] push_data;
  logic        push_skip_lo;
  logic        push_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic        is_comp;
  logic [14:0] pc;
  logic [14:0] pc_next;
  logic        pop;
  logic [3:0]  count;

  int total = 0;
  int bad   = 0;

  rv_fetch_queue #(.IADDR_SPACE_BITS(16), .HW(16), .DEPTH_BITS(3)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_reset_pc(reset_pc),
    .i_flush(flush), .i_flush_pc(flush_pc),
    .i_push_valid(push_valid), .i_push_data(push_data), .i_push_skip_lo(push_skip_lo),
    .o_push_ready(push_ready), .o_instr_valid(instr_valid), .o_instr(instr),
    .o_is_comp(is_comp), .o_pc(pc), .o_pc_next(pc_next), .i_pop(pop), .o_count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic [14:0] fpc;
    logic        pv;
    logic [31:0] pd;
    logic        sk;
    logic        pp;
    logic [3:0]  e_cnt;
    logic        e_val;
    logic        chk_i;
    logic [31:0] e_instr;
    logic [14:0] e_pc;
    logic [14:0] e_pcn;
    logic        e_rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fl, input logic [14:0] fpc, input logic pv,
                       input logic [31:0] pd, input logic sk, input logic pp);
    flush = fl; flush_pc = fpc; push_valid = pv; push_data = pd; push_skip_lo = sk; pop = pp;
  endtask

  // Reference model: a plain queue of halfwords plus a head PC.
  logic [15:0] mq[$];
  logic [14:0] mpc;

  function automatic logic m_comp();
    return (mq.size() > 0) && (mq[0][1:0] != 2'b11);
  endfunction

  function automatic logic m_valid();
    return m_comp() || (mq.size() >= 2);
  endfunction

  initial begin
    logic        comp, mvalid, mready;
    logic        r_fl, r_pv, r_sk, r_pp;
    logic [14:0] r_fpc;
    logic [31:0] r_pd;
    logic [31:0] e_instr;

    reset_n = 1'b0; reset_pc = 15'h0100;
    drive(1'b0, 15'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(); step();
    reset_n = 1'b1;
    chk("rst_cnt",   {28'h0, count},       32'd0);
    chk("rst_valid", {31'h0, instr_valid}, 32'd0);
    chk("rst_ready", {31'h0, push_ready},  32'd1);
    chk("rst_pc",    {17'h0, pc},          32'h0100);

    //                  fl    fpc       pv    pd            sk    pp    cnt   val   chk   instr         pc        pcn       rdy
    vecs.push_back(vec_t'{1'b0, 15'h000, 1'b1, 32'h00138593, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 32'h00138593, 15'h0100, 15'h0102, 1'b1});
    vecs.push_back(vec_t'{1'b0, 15'h000, 1'b0, 32'h0,        1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 32'h0,        15'h0102, 15'h0104, 1'b1});
    vecs.push_back(vec_t'{1'b1, 15'h100, 1'b0, 32'h0,        1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0,        15'h0100, 15'h0102, 1'b1});
    vecs.push_back(vec_t'{1'b0, 15'h000, 1'b1, 32'h45014581, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 32'h00004581, 15'h0100, 15'h0101, 1'b1});
    vecs.push_back(vec_t'{1'b0, 15'h000, 1'b0, 32'h0,        1'b0, 1'b1, 4'd1, 1'b1, 1'b1, 32'h00004501, 15'h0101, 15'h0102, 1'b1});
    vecs.push_back(vec_t'{1'b0, 15'h000, 1'b0, 32'h0,        1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 32'h0,        15'h0102, 15'h0104, 1'b1});
    vecs.push_back(vec_t'{1'b1, 15'h201, 1'b0, 32'h0,        1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0,        15'h0201, 15'h0203, 1'b1});
    vecs.push_back(vec_t'{1'b0, 15'h000, 1'b1, 32'h0513AAAA, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 32'h0,        15'h0201, 15'h0203, 1'b1});
    vecs.push_back(vec_t'{1'b0, 15'h000, 1'b0, 32'h0,        1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 32'h0,        15'h0201, 15'h0203, 1'b1});
    vecs.push_back(vec_t'{1'b0, 15'h000, 1'b1, 32'h12340093, 1'b0, 1'b0, 4'd3, 1'b1, 1'b1, 32'h00930513, 15'h0201, 15'h0203, 1'b1});
    vecs.push_back(vec_t'{1'b0, 15'h000, 1'b0, 32'h0,        1'b0, 1'b1, 4'd1, 1'b1, 1'b1, 32'h00001234, 15'h0203, 15'h0204, 1'b1});
    vecs.push_back(vec_t'{1'b1, 15'h300, 1'b0, 32'h0,        1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0,        15'h0300, 15'h0302, 1'b1});
    vecs.push_back(vec_t'{1'b0, 15'h000, 1'b1, 32'h00138593, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 32'h00138593, 15'h0300, 15'h0302, 1'b1});
    vecs.push_back(vec_t'{1'b0, 15'h000, 1'b1, 32'h00238613, 1'b0, 1'b0, 4'd4, 1'b1, 1'b1, 32'h00138593, 15'h0300, 15'h0302, 1'b1});
    vecs.push_back(vec_t'{1'b1, 15'h400, 1'b1, 32'h45014581, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 32'h0,        15'h0400, 15'h0402, 1'b1});
    vecs.push_back(vec_t'{1'b0, 15'h000, 1'b1, 32'h45014581, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 32'h00004581, 15'h0400, 15'h0401, 1'b1});
    vecs.push_back(vec_t'{1'b1, 15'h500, 1'b0, 32'h0,        1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0,        15'h0500, 15'h0502, 1'b1});
    vecs.push_back(vec_t'{1'b0, 15'h000, 1'b1, 32'h00138593, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 32'h00138593, 15'h0500, 15'h0502, 1'b1});
    vecs.push_back(vec_t'{1'b0, 15'h000, 1'b1, 32'h00238613, 1'b0, 1'b0, 4'd4, 1'b1, 1'b1, 32'h00138593, 15'h0500, 15'h0502, 1'b1});
    vecs.push_back(vec_t'{1'b0, 15'h000, 1'b1, 32'h00338693, 1'b0, 1'b0, 4'd6, 1'b1, 1'b1, 32'h00138593, 15'h0500, 15'h0502, 1'b1});
    vecs.push_back(vec_t'{1'b0, 15'h000, 1'b1, 32'h00438713, 1'b0, 1'b0, 4'd8, 1'b1, 1'b1, 32'h00138593, 15'h0500, 15'h0502, 1'b0});
    vecs.push_back(vec_t'{1'b0, 15'h000, 1'b1, 32'h00538793, 1'b0, 1'b0, 4'd8, 1'b1, 1'b1, 32'h00138593, 15'h0500, 15'h0502, 1'b0});
    vecs.push_back(vec_t'{1'b0, 15'h000, 1'b1, 32'h00538793, 1'b0, 1'b1, 4'd6, 1'b1, 1'b1, 32'h00238613, 15'h0502, 15'h0504, 1'b1});
    vecs.push_back(vec_t'{1'b0, 15'h000, 1'b1, 32'h00538793, 1'b0, 1'b1, 4'd6, 1'b1, 1'b1, 32'h00338693, 15'h0504, 15'h0506, 1'b1});
    vecs.push_back(vec_t'{1'b1, 15'h7FFF,1'b0, 32'h0,        1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0,        15'h7FFF, 15'h0001, 1'b1});
    vecs.push_back(vec_t'{1'b0, 15'h000, 1'b1, 32'h45014581, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 32'h00004581, 15'h7FFF, 15'h0000, 1'b1});
    vecs.push_back(vec_t'{1'b0, 15'h000, 1'b0, 32'h0,        1'b0, 1'b1, 4'd1, 1'b1, 1'b1, 32'h00004501, 15'h0000, 15'h0001, 1'b1});

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].fl, vecs[k].fpc, vecs[k].pv, vecs[k].pd, vecs[k].sk, vecs[k].pp);
      step();
      chk($sformatf("v%0d_cnt", k),   {28'h0, count},       {28'h0, vecs[k].e_cnt});
      chk($sformatf("v%0d_valid", k), {31'h0, instr_valid}, {31'h0, vecs[k].e_val});
      chk($sformatf("v%0d_ready", k), {31'h0, push_ready},  {31'h0, vecs[k].e_rdy});
      chk($sformatf("v%0d_pc", k),    {17'h0, pc},          {17'h0, vecs[k].e_pc});
      chk($sformatf("v%0d_pcn", k),   {17'h0, pc_next},     {17'h0, vecs[k].e_pcn});
      if (vecs[k].chk_i) chk($sformatf("v%0d_instr", k), instr, vecs[k].e_instr);
    end

    // Reset while push and pop are active (queue holds one RVC halfword).
    reset_n = 1'b0; reset_pc = 15'h0100;
    drive(1'b0, 15'h0, 1'b1, 32'h45014581, 1'b0, 1'b1);
    step();
    reset_n = 1'b1;
    drive(1'b0, 15'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rst2_cnt",   {28'h0, count},       32'd0);
    chk("rst2_valid", {31'h0, instr_valid}, 32'd0);
    chk("rst2_pc",    {17'h0, pc},          32'h0100);

    // Randomized phase against the reference model.
    r_fpc = 15'($urandom);
    drive(1'b1, r_fpc, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    mq.delete();
    mpc = r_fpc;
    for (int n = 0; n < 2000; n++) begin
      r_fl  = ($urandom_range(99, 0) < 3);
      r_fpc = 15'($urandom);
      r_pv  = ($urandom_range(99, 0) < 60);
      r_pd  = $urandom;
      r_sk  = ($urandom_range(99, 0) < 10);
      r_pp  = ($urandom_range(99, 0) < 45);
      comp   = m_comp();
      mvalid = m_valid();
      mready = (mq.size() <= QS - 2);
      drive(r_fl, r_fpc, r_pv, r_pd, r_sk, r_pp);
      step();
      if (r_fl) begin
        mq.delete();
        mpc = r_fpc;
      end else begin
        if (r_pp && mvalid) begin
          void'(mq.pop_front());
          if (!comp) void'(mq.pop_front());
          mpc = mpc + (comp ? 15'd1 : 15'd2);
        end
        if (r_pv && mready) begin
          if (!r_sk) mq.push_back(r_pd[15:0]);
          mq.push_back(r_pd[31:16]);
        end
      end
      comp = m_comp();
      chk($sformatf("r%0d_cnt", n),   {28'h0, count},       32'(mq.size()));
      chk($sformatf("r%0d_valid", n), {31'h0, instr_valid}, {31'h0, m_valid()});
      chk($sformatf("r%0d_ready", n), {31'h0, push_ready},  {31'h0, (mq.size() <= QS - 2)});
      chk($sformatf("r%0d_pc", n),    {17'h0, pc},          {17'h0, mpc});
      chk($sformatf("r%0d_pcn", n),   {17'h0, pc_next},     {17'h0, 15'(mpc + (comp ? 15'd1 : 15'd2))});
      if (m_valid()) begin
        e_instr = comp ? {16'h0, mq[0]} : {mq[1], mq[0]};
        chk($sformatf("r%0d_instr", n), instr, e_instr);
        chk($sformatf("r%0d_comp", n),  {31'h0, is_comp}, {31'h0, comp});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
